// File: rtl/mem_stage_lsu.sv
// ============================================================================
// mem_stage_lsu
// ----------------------------------------------------------------------------
// Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It sits
// between EX/MEM and MEM/WB, turns an EX/MEM load or store into a single
// valid/ready transaction on the data-memory bus, extends returned load data
// and stalls the whole pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) while the
// access is outstanding.
//
// Parameters:
//   TIMEOUT_CYCLES : maximum cycles spent in REQ+RESP before the access is
//                    abandoned (bus_err pulse, MemReadData = 0). 0 disables.
//
// Optional feature (compile-time macro LSU_MISALIGN_TRAP_EN):
//   defined   : misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0)
//               raise 'misaligned' in IDLE, issue no bus transaction and
//               do not stall.
//   undefined : 'misaligned' is tied low and the low address bits are forced
//               to the access-size alignment before lane/extract logic.
//
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-low reset
//   MemRead      in   load request from EX/MEM
//   MemWrite     in   store request from EX/MEM (wins over MemRead)
//   funct3       in   RV32I load/store size/sign encoding
//   ALUresult    in   byte address
//   WriteData    in   store data, right-aligned
//   bus_valid    out  request valid
//   bus_ready    in   request accepted
//   bus_we       out  1 = store
//   bus_addr     out  word-aligned address
//   bus_wdata    out  lane-replicated store data
//   bus_wstrb    out  byte enables (lanes touched by the access)
//   bus_rdata    in   read word
//   bus_rvalid   in   read data valid
//   MemReadData  out  extended load result to MEM/WB
//   stall        out  pipeline hold
//   bus_err      out  one-cycle timeout pulse (asserted in DONE)
//   misaligned   out  misaligned access flag
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALUresult,
    input  logic [31:0] WriteData,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    output logic [31:0] MemReadData,
    output logic        stall,
    output logic        bus_err,
    output logic        misaligned
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit so
    // the declaration stays legal when the timeout is disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic             access;
    logic             is_store;
    logic             sz_byte;
    logic             sz_half;
    logic             misalign_hit;
    logic             start_req;
    logic             load_done;
    logic             timeout_hit;
    logic             timeout_fire;
    logic [1:0]       raw_off;
    logic [1:0]       eff_off;
    logic [1:0]       lat_off;
    logic [2:0]       lat_funct3;
    logic [3:0]       req_wstrb;
    logic [31:0]      req_wdata;
    logic [15:0]      lane_bits;
    logic [31:0]      load_ext;
    logic [CNT_W-1:0] to_cnt;

    assign access   = MemRead | MemWrite;
    assign is_store = MemWrite;
    assign raw_off  = ALUresult[1:0];

    // Access size decode. Stores only know SB/SH; every other store encoding
    // is treated as a word. Loads share size between signed/unsigned forms
    // (funct3[2] is the unsigned bit), reserved encodings fall to word.
    always_comb begin
        sz_byte = 1'b0;
        sz_half = 1'b0;
        if (is_store) begin
            sz_byte = (funct3 == 3'b000);
            sz_half = (funct3 == 3'b001);
        end else begin
            sz_byte = (funct3[1:0] == 2'b00);
            sz_half = (funct3[1:0] == 2'b01);
        end
    end

    // Lane placement. The offset is forced to the access-size alignment so a
    // halfword never straddles lanes 1/2 and a word always uses all lanes.
    // Loads reuse the same strobe so the bus sees which lanes are of interest.
    always_comb begin
        eff_off   = 2'b00;
        req_wstrb = 4'b1111;
        req_wdata = WriteData;
        if (sz_byte) begin
            eff_off   = raw_off;
            req_wstrb = 4'b0001 << raw_off;
            req_wdata = {4{WriteData[7:0]}};
        end else if (sz_half) begin
            eff_off   = {raw_off[1], 1'b0};
            req_wstrb = 4'b0011 << {raw_off[1], 1'b0};
            req_wdata = {2{WriteData[15:0]}};
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_hit = (sz_half & raw_off[0]) |
                          ((funct3 == 3'b010) & (raw_off != 2'b00));
`else
    assign misalign_hit = 1'b0;
`endif

    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Load extraction: bring the addressed byte/half down to bit 0, then
    // extend according to the funct3 latched when the request was issued.
    assign lane_bits = 16'(bus_rdata >> {lat_off, 3'b000});

    always_comb begin
        load_ext = bus_rdata;
        case (lat_funct3)
            3'b000:  load_ext = {{24{lane_bits[7]}}, lane_bits[7:0]};
            3'b100:  load_ext = {24'd0, lane_bits[7:0]};
            3'b001:  load_ext = {{16{lane_bits[15]}}, lane_bits[15:0]};
            3'b101:  load_ext = {16'd0, lane_bits[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs. A successful handshake or rvalid in
    // the same cycle as the timeout limit takes priority over abandoning.
    // DONE never starts a new access: it is the cycle the pipeline advances.
    always_comb begin
        state_next   = state;
        bus_valid    = 1'b0;
        stall        = 1'b0;
        misaligned   = 1'b0;
        start_req    = 1'b0;
        load_done    = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                misaligned = access & misalign_hit;
                if (access && !misalign_hit) begin
                    stall      = 1'b1;
                    start_req  = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_valid = 1'b1;
                stall     = 1'b1;
                if (bus_ready) begin
                    state_next = bus_we ? ST_DONE : ST_RESP;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = ST_DONE;
                end
            end
            ST_RESP: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    load_done  = 1'b1;
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request registers, load result and error pulse. Request fields are
    // captured once in IDLE so they stay stable until the bus accepts them.
    // MemReadData only moves on a completed load or on a timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_wstrb   <= '0;
            bus_we      <= 1'b0;
            lat_funct3  <= '0;
            lat_off     <= '0;
            MemReadData <= '0;
            bus_err     <= 1'b0;
        end else begin
            if (start_req) begin
                bus_addr   <= {ALUresult[31:2], 2'b00};
                bus_wdata  <= req_wdata;
                bus_wstrb  <= req_wstrb;
                bus_we     <= is_store;
                lat_funct3 <= funct3;
                lat_off    <= eff_off;
            end
            if (load_done) begin
                MemReadData <= load_ext;
            end else if (timeout_fire) begin
                MemReadData <= '0;
            end
            bus_err <= timeout_fire;
        end
    end

    // Timeout counter: runs across REQ and RESP combined and clears whenever
    // the FSM leaves them, so each access starts with a fresh budget.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if ((TIMEOUT_CYCLES != 0) &&
                     (state == ST_REQ || state == ST_RESP) &&
                     (state_next == ST_REQ || state_next == ST_RESP)) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// tb_mem_stage_lsu
// ----------------------------------------------------------------------------
// Bench for mem_stage_lsu (TIMEOUT_CYCLES = 8). A driver issues directed and
// random loads/stores, a bus slave answers with configurable ready/rvalid
// delays, and a monitor compares bus requests and completions against
// expectations queued by the driver from a byte-lane reference model.
// ============================================================================
module tb_mem_stage_lsu;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUresult;
    logic [31:0] WriteData;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [31:0] MemReadData;
    logic        stall;
    logic        bus_err;
    logic        misaligned;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] mrd;
        logic        err;
        logic        hs;
        int          lat;
    } txn_t;

    txn_t        txn_q[$];
    int          checks;
    int          passes;
    logic [31:0] model_mrd;

    // Slave configuration written by the driver before each access.
    int          cfg_rdy;
    int          cfg_rv;
    logic [31:0] cfg_word;

    mem_stage_lsu #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .funct3      (funct3),
        .ALUresult   (ALUresult),
        .WriteData   (WriteData),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_rdata   (bus_rdata),
        .bus_rvalid  (bus_rvalid),
        .MemReadData (MemReadData),
        .stall       (stall),
        .bus_err     (bus_err),
        .misaligned  (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: an access touches n consecutive byte lanes starting at
    // the offset rounded down to n. Store data byte j is WriteData byte j%n;
    // load data is those lanes as an n-byte integer, optionally sign-extended.
    function automatic txn_t modelTxn(input logic rd, input logic wr,
                                      input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [31:0] rword,
                                      input int rdy, input int rv, output logic trap);
        txn_t   t;
        int     n;
        int     o;
        int     start;
        int     busy;
        bit     sgn;
        longint v;
        if (wr) n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        sgn   = !wr && (f3 == 3'd0 || f3 == 3'd1);
        o     = int'(addr % 4);
        start = o - (o % n);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (n == 2 && (o % 2) != 0) || (f3 == 3'd2 && o != 0);
`else
        trap = 1'b0;
`endif
        t.addr = addr - 32'(o);
        t.we   = wr;
        for (int j = 0; j < 4; j++) begin
            t.wstrb[j]       = (j >= start) && (j < start + n);
            t.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
        end
        v = {32'd0, rword};
        v = (v >> (8 * start)) % (64'sd1 <<< (8 * n));
        if (sgn && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
        t.mrd = (wr || !rd) ? model_mrd : v[31:0];
        if (wr) t.mrd = model_mrd;
        busy = rdy + 1 + (wr ? 0 : rv);
        t.hs  = (rdy + 1 <= TO);
        t.err = (busy > TO);
        t.lat = t.err ? 1 + TO : 1 + busy;
        if (t.err) t.mrd = 32'd0;
        return t;
    endfunction

    // Issue one access, hold it until the pipeline is released (DONE, or an
    // immediate trap), with a bounded wait.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rword, input int rdy, input int rv);
        txn_t t;
        logic trap;
        bit   done;
        t = modelTxn(rd, wr, f3, addr, wd, rword, rdy, rv, trap);
        @(negedge clk);
        cfg_rdy   = rdy;
        cfg_rv    = rv;
        cfg_word  = rword;
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        ALUresult = addr;
        WriteData = wd;
        if (!trap) begin
            txn_q.push_back(t);
            model_mrd = t.mrd;
        end
        #1;
        checkOutput("misaligned", 32'(misaligned), 32'(trap));
        checkOutput("idle_stall", 32'(stall), 32'(!trap));
        done = 0;
        for (int c = 0; c < 60; c++) begin
            if (!stall) begin
                done = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!done) checkOutput("done_budget", 32'(stall), 32'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MemRead  = 1'b0;
            MemWrite = 1'b0;
        end
    endtask

    // Bus slave: raises ready after cfg_rdy waiting cycles of bus_valid, and
    // for loads returns cfg_word with rvalid cfg_rv cycles after acceptance.
    initial begin
        int   wcnt;
        int   rv_cnt;
        bit   in_req;
        wcnt       = 0;
        rv_cnt     = 0;
        in_req     = 0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = cfg_word;
                end
            end
            if (bus_valid) begin
                if (!in_req) begin
                    in_req = 1;
                    wcnt   = 0;
                end
                if (wcnt >= cfg_rdy) begin
                    bus_ready = 1'b1;
                    in_req    = 0;
                    if (!bus_we) rv_cnt = cfg_rv;
                end else begin
                    wcnt++;
                end
            end else begin
                in_req = 0;
            end
        end
    end

    // Monitor: while a request is presented it must match the queued
    // expectation every cycle; when stall falls after a stalled run, the
    // transaction has completed and its result, latency and error are checked.
    initial begin
        int   stall_run;
        logic hs_seen;
        txn_t t;
        stall_run = 0;
        hs_seen   = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                txn_q.delete();
                stall_run = 0;
                hs_seen   = 1'b0;
            end else begin
                if (bus_valid) begin
                    if (txn_q.size() == 0) begin
                        checkOutput("idle_bus_valid", 32'(bus_valid), 32'd0);
                    end else begin
                        checkOutput("bus_addr", bus_addr, txn_q[0].addr);
                        checkOutput("bus_we", 32'(bus_we), 32'(txn_q[0].we));
                        checkOutput("bus_wdata", bus_wdata, txn_q[0].wdata);
                        checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(txn_q[0].wstrb));
                        if (bus_ready) hs_seen = 1'b1;
                    end
                end
                if (stall) begin
                    stall_run++;
                end else if (stall_run > 0) begin
                    if (txn_q.size() == 0) begin
                        checkOutput("unexpected_done", 32'(stall_run), 32'd0);
                    end else begin
                        t = txn_q.pop_front();
                        checkOutput("stall_cycles", 32'(stall_run), 32'(t.lat));
                        checkOutput("bus_err", 32'(bus_err), 32'(t.err));
                        checkOutput("MemReadData", MemReadData, t.mrd);
                        checkOutput("handshake", 32'(hs_seen), 32'(t.hs));
                    end
                    stall_run = 0;
                    hs_seen   = 1'b0;
                end
            end
        end
    end

    initial begin
        txn_t t;
        logic trap;
        checks    = 0;
        passes    = 0;
        model_mrd = 32'd0;
        cfg_rdy   = 0;
        cfg_rv    = 1;
        cfg_word  = 32'd0;
        rst       = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        funct3    = 3'd0;
        ALUresult = 32'd0;
        WriteData = 32'd0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_bus_valid", 32'(bus_valid), 32'd0);
        checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        checkOutput("rst_MemReadData", MemReadData, 32'd0);
        checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
        checkOutput("rst_misaligned", 32'(misaligned), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idleCycles(2);

        // Directed cases
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1);
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0, 1);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'h0, 32'h12F4_5678, 0, 1);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8001_1234, 4, 1);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 1);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_3004, 32'h1357_9BDF, 32'h0, 1, 1);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, 100, 1);
        idleCycles(1);

        // Random traffic, kept inside the timeout budget
        for (int i = 0; i < 60; i++) begin
            logic rd;
            logic wr;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            applyStimulus(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                          int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
            idleCycles(int'($urandom_range(0, 2)));
        end
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 0, 1);

        // Reset while a load waits for rvalid; the late rvalid must be ignored
        t = modelTxn(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 3, trap);
        @(negedge clk);
        cfg_rdy   = 0;
        cfg_rv    = 3;
        cfg_word  = 32'hDEAD_BEEF;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        funct3    = 3'b010;
        ALUresult = 32'h0000_4000;
        txn_q.push_back(t);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        MemRead = 1'b0;
        model_mrd = 32'd0;
        @(negedge clk);
        #1;
        checkOutput("rstmid_bus_valid", 32'(bus_valid), 32'd0);
        checkOutput("rstmid_stall", 32'(stall), 32'd0);
        checkOutput("rstmid_MemReadData", MemReadData, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("late_rvalid_MemReadData", MemReadData, 32'd0);
        checkOutput("late_rvalid_stall", 32'(stall), 32'd0);
        idleCycles(2);

        @(negedge clk);
        #2;
        checkOutput("scoreboard_drain", 32'(txn_q.size()), 32'd0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Sits between EX/MEM and MEM/WB. Takes the EX/MEM address, store data and control, and runs a valid/ready transaction on the data-memory bus.
- Sign/zero-extends load data and drives the stall consumed by the pipeline registers, including the MEM/WB stall input.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+RESP before the access is abandoned; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM
- funct3  in  3  access size/sign (RV32I load/store encoding)
- ALUresult  in  32  byte address
- WriteData  in  32  store data, right-aligned
- bus_valid  out  1  request valid
- bus_ready  in  1  request accepted
- bus_we  out  1  1=store
- bus_addr  out  32  word-aligned address (addr[1:0]=0)
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables
- bus_rdata  in  32  read word
- bus_rvalid  in  1  read data valid
- MemReadData  out  32  extended load result to MEM/WB
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- bus_err  out  1  one-cycle timeout pulse
- misaligned  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low; it is sampled only on posedge clk.
- Reset values:
  - State = IDLE.
  - bus_valid, bus_we, bus_err, misaligned = 0.
  - bus_addr, bus_wdata, MemReadData = 0; bus_wstrb = 0.
  - Timeout counter = 0.
- Reset mid-transaction returns to IDLE at that edge. bus_valid is low from the next cycle. A later bus_rvalid arriving in IDLE is ignored.
- Access = MemRead | MemWrite. If both are set, MemWrite wins and no read is performed.
- State machine:
  - IDLE:
    - If access (and not trapped as misaligned), latch address, wdata, wstrb, funct3 and we, then go to REQ.
    - stall = access, combinationally, in that cycle.
  - REQ:
    - bus_valid=1 and stall=1.
    - On bus_valid & bus_ready: a store goes to DONE, a load goes to RESP.
    - Latched outputs stay stable until accepted.
  - RESP:
    - stall=1.
    - On bus_rvalid, capture the extended data into MemReadData and go to DONE.
    - bus_rvalid in the same cycle as acceptance is not possible; the earliest is the cycle after.
  - DONE:
    - stall=0, so the pipeline advances this cycle.
    - No new access is started in DONE.
    - Next state is IDLE.
- Latency (stall cycles):
  - Store with bus_ready=1 immediately: 2 (IDLE, REQ).
  - Load with 1-cycle rvalid: 3.
- Store lane placement (o = addr[1:0]):
  - SB (000): wstrb = 0001<<o; wdata = {4{WriteData[7:0]}}.
  - SH (001): wstrb = 0011<<(o & 2); wdata = {2{WriteData[15:0]}}.
  - SW (010) and other encodings: wstrb = 1111; wdata = WriteData.
- Load extraction from the word:
  - LB (000): byte o, sign-extended.
  - LBU (100): byte o, zero-extended.
  - LH (001): half o[1], sign-extended.
  - LHU (101): half o[1], zero-extended.
  - LW (010) and reserved encodings: full word.
- MemReadData holds its value until the next completed load. Stores and idle cycles do not change it.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments each cycle in REQ/RESP and clears on leaving them.
  - When it reaches TIMEOUT_CYCLES: drop bus_valid, set MemReadData=0, pulse bus_err for one cycle in DONE, then go to DONE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - In IDLE, a misaligned access raises misaligned=1 combinationally. It issues no bus transaction, sets stall=0 and leaves MemReadData unchanged.
- Undefined:
  - misaligned is tied 0.
  - Address low bits are forced to the access-size alignment (halfword: o&2; word: 0) before lane and extract logic.

Test Plan:
- Reset mid-RESP: assert rst=0 with bus_rvalid pending -> next cycle state IDLE, bus_valid=0, stall=0. A late rvalid with rdata=0xDEADBEEF leaves MemReadData=0.
- SB: addr=0x1003, WriteData=0x000000A5, bus_ready=1 immediately -> bus_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, bus_we=1. stall high for exactly 2 cycles.
- LB/LBU: addr=0x2002, rdata=0x12F45678, rvalid 1 cycle after accept -> LB MemReadData=0xFFFFFFF4; LBU=0x000000F4. Each has 3 stall cycles.
- LH: addr=0x2002, rdata=0x8001_1234, bus_ready delayed 4 cycles -> MemReadData=0xFFFF8001. bus_addr/wstrb stable for all 4 wait cycles.
- Timeout with TIMEOUT_CYCLES=8: bus_ready held 0 -> bus_valid drops after 8 cycles, bus_err pulses 1 cycle, MemReadData=0, stall releases.
- MISALIGN: LW at addr=0x3001 -> with LSU_MISALIGN_TRAP_EN, misaligned=1, no bus_valid, stall=0. Without it, bus_addr=0x3000, wstrb=1111.
